// File: rtl/midi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | midi_pkg                                                                   |
// | Shared MIDI status constants, parser state encoding and message lengths.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package midi_pkg;

  localparam logic [7:0] NOTE_OFF    = 8'h80;
  localparam logic [7:0] NOTE_ON     = 8'h90;
  localparam logic [7:0] POLY_AT     = 8'hA0;
  localparam logic [7:0] CTRL_CHG    = 8'hB0;
  localparam logic [7:0] PROG_CHG    = 8'hC0;
  localparam logic [7:0] CHAN_AT     = 8'hD0;
  localparam logic [7:0] PITCH_BEND  = 8'hE0;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] MTC_QF      = 8'hF1;
  localparam logic [7:0] SONG_POS    = 8'hF2;
  localparam logic [7:0] SONG_SEL    = 8'hF3;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_FIRST    = 8'hF8;
  localparam logic [7:0] ACT_SENSE   = 8'hFE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    RUN   = 2'd2,
    SYSEX = 2'd3
  } parser_state_t;

  // Number of data bytes following a status byte; undefined system codes give 0.
  function automatic logic [1:0] data_len(input logic [7:0] status);
    logic [7:0] hi;
    hi       = status & 8'hF0;
    data_len = 2'd0;
    if (hi == PROG_CHG || hi == CHAN_AT)
      data_len = 2'd1;
    else if (hi == NOTE_OFF || hi == NOTE_ON || hi == POLY_AT ||
             hi == CTRL_CHG || hi == PITCH_BEND)
      data_len = 2'd2;
    else if (status == MTC_QF || status == SONG_SEL)
      data_len = 2'd1;
    else if (status == SONG_POS)
      data_len = 2'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_active_sense_wd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | midi_active_sense_wd                                                       |
// | Active-sensing watchdog: armed by FE, reloaded by any byte, one-cycle     |
// | expire pulse then disarms. Built only with MIDI_ACTIVE_SENSE_EN.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`ifdef MIDI_ACTIVE_SENSE_EN
module midi_active_sense_wd #(
  parameter int unsigned TIMEOUT_CYC = 7500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic kick,
  output logic expire
);

  localparam logic [31:0] RELOAD = 32'(TIMEOUT_CYC - 1);

  logic        armed_q, armed_d;
  logic [31:0] cnt_q, cnt_d;
  logic        expire_q, expire_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      cnt_q    <= 32'd0;
      expire_q <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    armed_d  = armed_q;
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (armed_q) begin
      if (cnt_q == 32'd0) begin
        expire_d = 1'b1;
        armed_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end
    // A received byte always wins over a same-cycle expiry.
    if (kick) begin
      cnt_d    = RELOAD;
      expire_d = 1'b0;
      armed_d  = armed_q | arm;
    end
  end

  assign expire = expire_q;

endmodule
`endif
`default_nettype wire

// File: rtl/midi_rx_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | midi_rx_parser                                                             |
// | MIDI byte framing: running status, sysex, real-time split.                |
// | Optional active-sense watchdog via MIDI_ACTIVE_SENSE_EN.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 25000000,
  parameter int unsigned AS_TIMEOUT_MS = 300
) (
  input  logic       CLOCK_25,
  input  logic       reset_reg_N,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midibyte,
  output logic       sys_real,
  output logic [7:0] sys_real_dat,
  output logic       all_notes_off
);

  localparam int unsigned AS_CYCLES = CLK_HZ / 1000 * AS_TIMEOUT_MS;

  parser_state_t state_q, state_d;
  logic [7:0]    cur_status_q, cur_status_d;
  logic [7:0]    nr_q, nr_d;
  logic [7:0]    midibyte_q, midibyte_d;
  logic [7:0]    rt_dat_q, rt_dat_d;
  logic [1:0]    len_q, len_d;
  logic          byteready_q, byteready_d;
  logic          sys_real_q, sys_real_d;
  logic          clr_pend_q, clr_pend_d;
  logic          wd_expire;
  logic [7:0]    nr_inc;
  logic [1:0]    new_len;

`ifdef MIDI_ACTIVE_SENSE_EN
  midi_active_sense_wd #(
    .TIMEOUT_CYC(AS_CYCLES)
  ) u_wd (
    .clk   (CLOCK_25),
    .rst_n (reset_reg_N),
    .arm   (rx_valid && !rx_frame_err && (rx_byte == ACT_SENSE)),
    .kick  (rx_valid),
    .expire(wd_expire)
  );
  assign all_notes_off = wd_expire;
`else
  assign wd_expire     = 1'b0;
  assign all_notes_off = wd_expire & (AS_CYCLES == 0);
`endif

  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q      <= IDLE;
      cur_status_q <= 8'h00;
      nr_q         <= 8'h00;
      midibyte_q   <= 8'h00;
      rt_dat_q     <= 8'h00;
      len_q        <= 2'd0;
      byteready_q  <= 1'b0;
      sys_real_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_status_q <= cur_status_d;
      nr_q         <= nr_d;
      midibyte_q   <= midibyte_d;
      rt_dat_q     <= rt_dat_d;
      len_q        <= len_d;
      byteready_q  <= byteready_d;
      sys_real_q   <= sys_real_d;
      clr_pend_q   <= clr_pend_d;
    end
  end

  assign nr_inc  = (nr_q == 8'hFF) ? 8'hFF : nr_q + 8'd1;
  assign new_len = data_len(rx_byte);

  always_comb begin
    state_d      = state_q;
    // The final byte of a terminating message is presented with its status;
    // the status is dropped on the following cycle.
    cur_status_d = clr_pend_q ? 8'h00 : cur_status_q;
    clr_pend_d   = 1'b0;
    nr_d         = nr_q;
    midibyte_d   = midibyte_q;
    rt_dat_d     = rt_dat_q;
    len_d        = len_q;
    byteready_d  = 1'b0;
    sys_real_d   = 1'b0;

    if (wd_expire) begin
      state_d      = IDLE;
      cur_status_d = 8'h00;
    end

    if (rx_valid) begin
      if (rx_frame_err) begin
        state_d      = IDLE;
        cur_status_d = 8'h00;
      end else if (rx_byte >= RT_FIRST) begin
        sys_real_d = 1'b1;
        rt_dat_d   = rx_byte;
      end else if (rx_byte[7]) begin
        if (rx_byte == SYSEX_END) begin
          if (state_q == SYSEX) begin
            byteready_d = 1'b1;
            midibyte_d  = rx_byte;
            nr_d        = nr_inc;
            state_d     = IDLE;
            clr_pend_d  = 1'b1;
          end
        end else begin
          byteready_d  = 1'b1;
          cur_status_d = rx_byte;
          midibyte_d   = rx_byte;
          nr_d         = 8'h00;
          len_d        = new_len;
          if (rx_byte == SYSEX_START) begin
            state_d = SYSEX;
          end else if (new_len == 2'd0) begin
            state_d    = IDLE;
            clr_pend_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end else begin
        case (state_q)
          DATA: begin
            byteready_d = 1'b1;
            midibyte_d  = rx_byte;
            nr_d        = nr_inc;
            if (nr_inc == {6'd0, len_q}) begin
              if (cur_status_q[7:4] == 4'hF) begin
                state_d    = IDLE;
                clr_pend_d = 1'b1;
              end else begin
                state_d = RUN;
              end
            end
          end
          RUN: begin
            byteready_d = 1'b1;
            midibyte_d  = rx_byte;
            nr_d        = 8'd1;
            state_d     = (len_q == 2'd1) ? RUN : DATA;
          end
          SYSEX: begin
            byteready_d = 1'b1;
            midibyte_d  = rx_byte;
            nr_d        = nr_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign byteready    = byteready_q;
  assign cur_status   = cur_status_q;
  assign midibyte_nr  = nr_q;
  assign midibyte     = midibyte_q;
  assign sys_real     = sys_real_q;
  assign sys_real_dat = rt_dat_q;

endmodule
`default_nettype wire
